// File: rtl/regfile_write_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_scheduler_if
//  Description : Issue, writeback and register-file write-port bundle for
//                the register-file write scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_scheduler_if;
    // Issue side
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_rd_en;
    logic        issue_ready;

    // ALU writeback request
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;

    // Load writeback request
    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        mem_wb_ready;

    // Register-file write port and status
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        busy;
    logic        wb_error;

    // Requester side: decode/issue and both writeback paths
    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output mem_wb_valid, mem_wb_rd, mem_wb_data,
        input  issue_ready, alu_wb_ready, mem_wb_ready,
        input  rf_wr_en, rf_wr_addr, rf_wr_data, busy, wb_error
    );

    // Scheduler side
    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  mem_wb_valid, mem_wb_rd, mem_wb_data,
        output issue_ready, alu_wb_ready, mem_wb_ready,
        output rf_wr_en, rf_wr_addr, rf_wr_data, busy, wb_error
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_scheduler
//  Description : Pending-write scoreboard for the 32x32 register file with
//                RAW/WAW issue stall, plus a starvation-limited arbiter that
//                shares the single write port between ALU and load writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    regfile_write_scheduler_if.slave        bus
);

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_pending;
    logic [3:0]  r_starve_cnt;
    logic        r_rf_wr_en;
    logic [4:0]  r_rf_wr_addr;
    logic [31:0] r_rf_wr_data;
    logic        r_wb_error;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic        w_hazard;
    logic        w_issue_ready;
    logic        w_issue_fire;
    logic        w_alu_force;
    logic        w_alu_grant;
    logic        w_mem_grant;
    logic        w_wb_any;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_data;
    logic        w_wb_rd_nz;
    logic        w_wb_err;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_pending_next;

    // Hazard looks only at registered pending bits; a clear granted this
    // cycle does not release a stalled instruction until the next cycle.
    assign w_hazard = r_pending[bus.issue_rs1]
                    | r_pending[bus.issue_rs2]
                    | (bus.issue_rd_en & r_pending[bus.issue_rd]);

    assign w_issue_ready = !reset && !w_hazard;
    assign w_issue_fire  = bus.issue_valid && w_issue_ready;

    // The ALU is forced through once it has been starved long enough;
    // otherwise loads have priority. Grants never depend on rd/data.
    assign w_alu_force = bus.alu_wb_valid && (r_starve_cnt == c_STARVE_LIMIT);
    assign w_alu_grant = !reset && bus.alu_wb_valid
                       && (!bus.mem_wb_valid || w_alu_force);
    assign w_mem_grant = !reset && bus.mem_wb_valid && !w_alu_force;
    assign w_wb_any    = w_alu_grant || w_mem_grant;

    // Winner's destination and data
    assign w_wb_rd    = w_alu_grant ? bus.alu_wb_rd   : bus.mem_wb_rd;
    assign w_wb_data  = w_alu_grant ? bus.alu_wb_data : bus.mem_wb_data;
    assign w_wb_rd_nz = (w_wb_rd != 5'd0);

    // A granted writeback to a register with no outstanding write is an
    // error. This also covers the same-bit set/clear collision, because
    // an issue can only set a bit that is currently clear.
    assign w_wb_err = w_wb_any && w_wb_rd_nz && !r_pending[w_wb_rd];

    // x0 is hardwired: it never gets a pending bit or a clear.
    assign w_set_mask[0] = 1'b0;
    assign w_clr_mask[0] = 1'b0;

    generate
        for (genvar i = 1; i < 32; i++) begin : g_pending_mask
            assign w_set_mask[i] = w_issue_fire && bus.issue_rd_en
                                 && (bus.issue_rd == 5'(i));
            assign w_clr_mask[i] = w_wb_any && (w_wb_rd == 5'(i));
        end
    endgenerate

    // Set after clear so an issue set wins over a clear of the same bit.
    assign w_pending_next = (r_pending & ~w_clr_mask) | w_set_mask;

    // ------------------------------------------------------------------
    // Scoreboard, starvation counter, error flag and write-port register
    // ------------------------------------------------------------------
    // Update all tracking state and register the winning writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= 32'd0;
            r_starve_cnt <= 4'd0;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_addr <= 5'd0;
            r_rf_wr_data <= 32'd0;
            r_wb_error   <= 1'b0;
        end else begin
            r_pending <= w_pending_next;

            if (!bus.alu_wb_valid || w_alu_grant) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != c_STARVE_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            // Address/data hold when nothing is granted.
            r_rf_wr_en <= w_wb_any && w_wb_rd_nz;
            if (w_wb_any) begin
                r_rf_wr_addr <= w_wb_rd;
                r_rf_wr_data <= w_wb_data;
            end

            if (w_wb_err) begin
                r_wb_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.issue_ready  = w_issue_ready;
    assign bus.alu_wb_ready = w_alu_grant;
    assign bus.mem_wb_ready = w_mem_grant;
    assign bus.rf_wr_en     = r_rf_wr_en;
    assign bus.rf_wr_addr   = r_rf_wr_addr;
    assign bus.rf_wr_data   = r_rf_wr_data;
    assign bus.busy         = |r_pending;
    assign bus.wb_error     = r_wb_error;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_scheduler
//  Description : Directed self-checking bench. Expected register-file
//                writes are queued when a writeback is issued and compared
//                by an independent monitor when rf_wr_en appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_scheduler;

    logic clk;
    logic reset;

    regfile_write_scheduler_if bus ();

    regfile_write_scheduler #(
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected write: {addr[4:0], data[31:0]}
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;

    // 100 MHz-style clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid  = 1'b0;
        bus.issue_rs1    = 5'd0;
        bus.issue_rs2    = 5'd0;
        bus.issue_rd     = 5'd0;
        bus.issue_rd_en  = 1'b0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_rd    = 5'd0;
        bus.alu_wb_data  = 32'd0;
        bus.mem_wb_valid = 1'b0;
        bus.mem_wb_rd    = 5'd0;
        bus.mem_wb_data  = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rd_en);
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
        bus.issue_rd    = rd;
        bus.issue_rd_en = rd_en;
    endtask

    // Monitor: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                         bus.rf_wr_addr, bus.rf_wr_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(bus.rf_wr_addr), 32'(mon_e[36:32]));
                check("wr_data", bus.rf_wr_data, mon_e[31:0]);
            end
        end
    end

    // Expected grant pattern with both valids held: mem x4, then ALU.
    logic [9:0] starve_alu_exp;

    initial begin
        starve_alu_exp = 10'b10000_10000;  // bit k = ALU wins in cycle k
        reset = 1'b1;
        idle_inputs();

        // ---------------- Reset with all valids high ----------------
        issue(5'd1, 5'd2, 5'd3, 1'b1);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd4; bus.alu_wb_data = 32'h11;
        bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd5; bus.mem_wb_data = 32'h22;
        step();
        check("rst_issue_ready", 32'(bus.issue_ready), 0);
        check("rst_alu_ready",   32'(bus.alu_wb_ready), 0);
        check("rst_mem_ready",   32'(bus.mem_wb_ready), 0);
        step();
        check("rst_rf_wr_en",    32'(bus.rf_wr_en), 0);
        check("rst_busy",        32'(bus.busy), 0);
        check("rst_wr_addr",     32'(bus.rf_wr_addr), 0);
        check("rst_wr_data",     bus.rf_wr_data, 0);
        check("rst_wb_error",    32'(bus.wb_error), 0);
        idle_inputs();
        reset = 1'b0;
        #1;
        check("post_rst_issue_ready", 32'(bus.issue_ready), 1);

        // ---------------- RAW stall and release ----------------
        issue(5'd1, 5'd2, 5'd5, 1'b1);
        #1;
        check("issue_rd5_ready", 32'(bus.issue_ready), 1);
        step();
        check("busy_after_rd5", 32'(bus.busy), 1);
        issue(5'd5, 5'd0, 5'd6, 1'b1);
        #1;
        check("raw_stall", 32'(bus.issue_ready), 0);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd5; bus.alu_wb_data = 32'hDEADBEEF;
        #1;
        check("alu_grant_rd5", 32'(bus.alu_wb_ready), 1);
        check("mem_idle_rd5",  32'(bus.mem_wb_ready), 0);
        check("no_bypass",     32'(bus.issue_ready), 0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        bus.alu_wb_valid = 1'b0;
        #1;
        check("release_ready", 32'(bus.issue_ready), 1);
        check("wr_en_t1",      32'(bus.rf_wr_en), 1);
        step();                         // issue rd=6 accepted here
        idle_inputs();
        bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd6; bus.mem_wb_data = 32'h0000_0066;
        #1;
        check("mem_grant_rd6", 32'(bus.mem_wb_ready), 1);
        exp_q.push_back({5'd6, 32'h0000_0066});
        step();
        idle_inputs();
        step();
        check("busy_cleared", 32'(bus.busy), 0);
        check("no_err_raw",   32'(bus.wb_error), 0);

        // ---------------- Starvation (writes to x0) ----------------
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd0;
        bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("starve_alu_ready", 32'(bus.alu_wb_ready), 32'(starve_alu_exp[k]));
            check("starve_mem_ready", 32'(bus.mem_wb_ready), 32'(!starve_alu_exp[k]));
            step();
        end
        idle_inputs();
        step();
        check("starve_no_err", 32'(bus.wb_error), 0);

        // ---------------- x0 handling ----------------
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        step();
        idle_inputs();
        #1;
        check("x0_issue_busy", 32'(bus.busy), 0);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd0; bus.alu_wb_data = 32'h1234;
        #1;
        check("x0_wb_ready", 32'(bus.alu_wb_ready), 1);
        step();
        idle_inputs();
        check("x0_no_write", 32'(bus.rf_wr_en), 0);
        check("x0_no_err",   32'(bus.wb_error), 0);

        // ---------------- Erroneous writeback ----------------
        bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd7; bus.mem_wb_data = 32'h0000_0077;
        #1;
        check("err_mem_ready", 32'(bus.mem_wb_ready), 1);
        exp_q.push_back({5'd7, 32'h0000_0077});
        step();
        idle_inputs();
        check("err_set", 32'(bus.wb_error), 1);
        step();
        check("err_sticky", 32'(bus.wb_error), 1);

        // ---------------- Same-cycle set/clear, different bits ----------------
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        step();
        idle_inputs();
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd3; bus.alu_wb_data = 32'h0000_0033;
        #1;
        check("sim_issue_ready", 32'(bus.issue_ready), 1);
        check("sim_alu_ready",   32'(bus.alu_wb_ready), 1);
        exp_q.push_back({5'd3, 32'h0000_0033});
        step();
        idle_inputs();
        bus.issue_rs1 = 5'd3;
        #1;
        check("sim_rd3_clear", 32'(bus.issue_ready), 1);
        bus.issue_rs1 = 5'd9;
        #1;
        check("sim_rd9_set", 32'(bus.issue_ready), 0);
        idle_inputs();
        bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd9; bus.mem_wb_data = 32'h0000_0099;
        exp_q.push_back({5'd9, 32'h0000_0099});
        step();
        idle_inputs();
        step();
        check("sim_busy_clear", 32'(bus.busy), 0);

        // ---------------- Reset mid-flight ----------------
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        step();
        issue(5'd0, 5'd0, 5'd4, 1'b1);
        step();
        idle_inputs();
        check("mid_busy", 32'(bus.busy), 1);
        bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd3; bus.mem_wb_data = 32'h0000_00AB;
        reset = 1'b1;
        #1;
        check("mid_mem_ready", 32'(bus.mem_wb_ready), 0);
        step();
        reset = 1'b0;
        idle_inputs();
        check("mid_rf_wr_en", 32'(bus.rf_wr_en), 0);
        check("mid_busy_clr", 32'(bus.busy), 0);
        check("mid_err_clr",  32'(bus.wb_error), 0);
        bus.issue_rs1 = 5'd3; bus.issue_rs2 = 5'd4;
        #1;
        check("mid_ready", 32'(bus.issue_ready), 1);
        idle_inputs();

        step();
        step();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
